// File: rtl/spi_controller.sv
// SPI mode-0 controller: one 16-bit MSB-first frame {rw, addr, data} per accepted request.
// Define SPI_READBACK_EN to add req_rw, CIPO and rsp_rdata for register reads.
module spi_controller #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned HOLD_CYC    = 4,
    parameter int unsigned GAP_CYC     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
`ifdef SPI_READBACK_EN
    input  logic       req_rw,
    input  logic       CIPO,
    output logic [7:0] rsp_rdata,
`endif
    output logic       done,
    output logic       sclk,
    output logic       COPI,
    output logic       cs
);

    localparam int unsigned MAX_SH = (HALF_PERIOD > SETUP_CYC) ? HALF_PERIOD : SETUP_CYC;
    localparam int unsigned MAX_HG = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned MAX_C  = (MAX_SH > MAX_HG) ? MAX_SH : MAX_HG;
    localparam int unsigned CW     = $clog2(MAX_C);

    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);

    if (HALF_PERIOD < 3 || SETUP_CYC < 3 || HOLD_CYC < 3 || GAP_CYC < 3) begin : g_param_err
        $error("spi_controller: timing parameters must all be >= 3");
    end

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    // Only addr/data are held here; the frame MSB goes straight to COPI at accept.
    logic [14:0]   shreg;
    logic          frame_msb;

`ifdef SPI_READBACK_EN
    logic       rd_q;
    logic [7:0] rx_q;
    assign frame_msb = req_rw;
`else
    assign frame_msb = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            sclk      <= 1'b0;
            COPI      <= 1'b0;
            cs        <= 1'b1;
            req_ready <= 1'b1;
            done      <= 1'b0;
`ifdef SPI_READBACK_EN
            rd_q      <= 1'b0;
            rx_q      <= '0;
            rsp_rdata <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        shreg     <= {req_addr, req_wdata};
                        COPI      <= frame_msb;
                        cs        <= 1'b0;
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        state     <= StSetup;
`ifdef SPI_READBACK_EN
                        rd_q      <= ~req_rw;
`endif
                    end
                end
                StSetup: begin
                    if (cnt == SETUP_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= 4'd15;
                        state   <= StShift;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StShift: begin
                    if (cnt != HALF_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (!sclk) begin
                        cnt  <= '0;
                        sclk <= 1'b1;
                    end else begin
                        // End of a high half: falling edge, next bit or leave.
                        cnt  <= '0;
                        sclk <= 1'b0;
`ifdef SPI_READBACK_EN
                        if (rd_q && !bit_cnt[3]) rx_q <= {rx_q[6:0], CIPO};
`endif
                        if (bit_cnt == 4'd0) begin
                            COPI  <= 1'b0;
                            state <= StHold;
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                            COPI    <= shreg[14];
                            shreg   <= {shreg[13:0], 1'b0};
                        end
                    end
                end
                StHold: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        cs    <= 1'b1;
                        done  <= 1'b1;
                        state <= StGap;
`ifdef SPI_READBACK_EN
                        if (rd_q) rsp_rdata <= rx_q;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StGap: begin
                    if (cnt == GAP_LAST) begin
                        cnt       <= '0;
                        req_ready <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller; an in-bench SPI receiver model commits written registers.
// Cycle n of a frame is the clk period ending at the n-th rising edge after the accepting edge.
module tb_spi_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, done, sclk, COPI, cs;
    logic       v3 = 1'b0;
    logic       ready3, done3, sclk3, copi3, cs3;
`ifdef SPI_READBACK_EN
    logic       req_rw = 1'b1;
    logic       CIPO = 1'b0;
    logic [7:0] rsp_rdata, rdata3, rd_at_done;
    logic [7:0] cipo_byte = 8'h00;
`endif

    spi_controller u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SPI_READBACK_EN
        .req_rw(req_rw), .CIPO(CIPO), .rsp_rdata(rsp_rdata),
`endif
        .done(done), .sclk(sclk), .COPI(COPI), .cs(cs)
    );

    spi_controller #(.HALF_PERIOD(3), .SETUP_CYC(3), .HOLD_CYC(3), .GAP_CYC(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(ready3),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SPI_READBACK_EN
        .req_rw(1'b1), .CIPO(1'b0), .rsp_rdata(rdata3),
`endif
        .done(done3), .sclk(sclk3), .COPI(copi3), .cs(cs3)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver / timing monitor for the default-parameter DUT.
    int          acc_edge = 0, acc_prev = 0, n_acc = 0, n_done = 0;
    int          done_cyc = 0, ready_cyc = 0, gap_cnt = 0;
    int          rises = 0, last_rises = 0, run = 0, hi_len = 0, lo_len = 0, fall_n = 0;
    logic        gap_on = 1'b0, p_sclk = 1'b0, p_cs = 1'b1, p_ready = 1'b1;
    logic [15:0] rx = '0, last_frame = '0;
    logic [7:0]  regs [128];

    always @(negedge clk) begin
        if (req_ready && !p_ready) ready_cyc = cyc - acc_edge + 1;
        if (done) begin
            n_done++;
            done_cyc = cyc - acc_edge + 1;
            gap_on = 1'b1;
            gap_cnt = 0;
`ifdef SPI_READBACK_EN
            rd_at_done = rsp_rdata;
`endif
        end
        if (gap_on) begin
            if (req_ready) gap_on = 1'b0;
            else if (cs) gap_cnt++;
        end
        if (req_valid && req_ready) begin
            acc_prev = acc_edge;
            acc_edge = cyc + 1;
            n_acc++;
        end
        if (!cs && p_cs) begin
            rises = 0;
            fall_n = 0;
        end
        if (sclk != p_sclk) begin
            if (sclk && !cs) begin
                rx = {rx[14:0], COPI};
                rises++;
                if (rises > 1) lo_len = run;
            end
            if (!sclk && !cs) begin
                hi_len = run;
                fall_n++;
`ifdef SPI_READBACK_EN
                // Peripheral presents read data on the falls ahead of the last eight rises.
                if (fall_n >= 8 && fall_n <= 15) CIPO = cipo_byte[15-fall_n];
`endif
            end
            run = 1;
        end else begin
            run++;
        end
        if (cs && !p_cs) begin
            last_rises = rises;
            last_frame = rx;
            if (rises == 16 && rx[15]) regs[rx[14:8]] = rx[7:0];
        end
        p_sclk = sclk;
        p_cs = cs;
        p_ready = req_ready;
    end

    // Timing monitor for the minimum-parameter DUT.
    int   acc3 = 0, ready3_cyc = 0, run3 = 0, hi3 = 0, lo3 = 0, rises3 = 0;
    logic p_sclk3 = 1'b0, p_cs3 = 1'b1, p_ready3 = 1'b1;

    always @(negedge clk) begin
        if (ready3 && !p_ready3) ready3_cyc = cyc - acc3 + 1;
        if (v3 && ready3) acc3 = cyc + 1;
        if (!cs3 && p_cs3) rises3 = 0;
        if (sclk3 != p_sclk3) begin
            if (sclk3) begin
                rises3++;
                if (rises3 > 1) lo3 = run3;
            end else begin
                hi3 = run3;
            end
            run3 = 1;
        end else begin
            run3++;
        end
        p_sclk3 = sclk3;
        p_cs3 = cs3;
        p_ready3 = ready3;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] a, input logic [7:0] d);
        logic got;
        got = 1'b0;
        step();
        req_valid = 1'b1;
        req_addr = a;
        req_wdata = d;
        for (int k = 0; k < 400; k++) begin
            got = req_ready;
            step();
            if (got) break;
        end
        req_valid = 1'b0;
        check("issue_accept", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 400; k++) begin
            if (req_ready) break;
            step();
        end
        check(tag, {31'd0, req_ready}, 32'd1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_done, base_acc, b2b_base;
        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_cs", {31'd0, cs}, 32'd1);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_copi", {31'd0, COPI}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
`ifdef SPI_READBACK_EN
        check("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
`endif
        rst_n = 1'b1;
        step();

        // Single write 0x04 <= 0xA5.
        issue(7'h04, 8'hA5);
        wait_ready("t1_ready_timeout");
        check("t1_frame", {16'd0, last_frame}, 32'h84A5);
        check("t1_rises", last_rises, 16);
        check("t1_high_half", hi_len, 4);
        check("t1_low_half", lo_len, 4);
        check("t1_done_cycle", done_cyc, 137);
        check("t1_ready_cycle", ready_cyc, 141);
        check("t1_reg04", {24'd0, regs[4]}, 32'hA5);

        // Back-to-back with req_valid held high.
        b2b_base = n_acc;
        step();
        req_valid = 1'b1;
        req_addr = 7'h00;
        req_wdata = 8'h55;
        for (int k = 0; k < 400 && n_acc == b2b_base; k++) step();
        req_addr = 7'h01;
        req_wdata = 8'hAA;
        for (int k = 0; k < 400 && n_acc == b2b_base + 1; k++) step();
        req_valid = 1'b0;
        check("t2_accepts", n_acc - b2b_base, 2);
        wait_ready("t2_ready_timeout");
        check("t2_accept_spacing", acc_edge - acc_prev, 141);
        check("t2_gap_cs_high", gap_cnt, 4);
        check("t2_reg00", {24'd0, regs[0]}, 32'h55);
        check("t2_reg01", {24'd0, regs[1]}, 32'hAA);

        // Requests while busy are dropped.
        base_done = n_done;
        base_acc = n_acc;
        issue(7'h03, 8'h3C);
        repeat (9) step();
        req_valid = 1'b1;
        req_addr = 7'h7F;
        req_wdata = 8'hFF;
        step();
        req_valid = 1'b0;
        repeat (49) step();
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        wait_ready("t3_ready_timeout");
        check("t3_rises", last_rises, 16);
        check("t3_frame", {16'd0, last_frame}, 32'h833C);
        check("t3_done_pulses", n_done - base_done, 1);
        check("t3_accepts", n_acc - base_acc, 1);
        check("t3_reg7f", {24'd0, regs[127]}, 32'h00);

        // Reset during the low half of bit 7 (COPI is 1 there for 0xDA).
        issue(7'h04, 8'hDA);
        for (int k = 0; k < 200; k++) begin
            if (rises == 8 && !sclk) break;
            step();
        end
        step();
        rst_n = 1'b0;
        #1;
        check("t4_cs", {31'd0, cs}, 32'd1);
        check("t4_sclk", {31'd0, sclk}, 32'd0);
        check("t4_copi", {31'd0, COPI}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        check("t4_bits_sent", last_rises, 8);
        check("t4_reg04_kept", {24'd0, regs[4]}, 32'hA5);
        check("t4_ready", {31'd0, req_ready}, 32'd1);

        // Minimum timing parameters.
        step();
        v3 = 1'b1;
        step();
        v3 = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (ready3) break;
            step();
        end
        step();
        check("t5_latency", ready3_cyc, 106);
        check("t5_high_half", hi3, 3);
        check("t5_low_half", lo3, 3);

`ifdef SPI_READBACK_EN
        // Read of 0x02 returns 0x3C; a later write leaves rsp_rdata alone.
        cipo_byte = 8'h3C;
        req_rw = 1'b0;
        issue(7'h02, 8'h00);
        wait_ready("t6_read_timeout");
        check("t6_rdata_at_done", {24'd0, rd_at_done}, 32'h3C);
        req_rw = 1'b1;
        issue(7'h05, 8'h11);
        wait_ready("t6_write_timeout");
        check("t6_rdata_held", {24'd0, rsp_rdata}, 32'h3C);
        check("t6_reg05", {24'd0, regs[5]}, 32'h11);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
